fifo_sp_ctrl: RTL and testbench
===============================

FIFO_SP_CTRL -- requirements
Module: fifo_sp_ctrl

Interface
REQ-001 Parameter DEPTH, default 32, FIFO storage words in the attached single-port RAM (any value >= 2, not necessarily a power of 2).
REQ-002 Parameter DATA_WIDTH, default 8, data word width.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH), RAM address width.
REQ-004 Parameter CNT_WIDTH, default $clog2(DEPTH+2), occupancy count width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 wr_valid  input  1  producer offers wr_data.
REQ-008 wr_ready  output  1  controller accepts wr_data this cycle.
REQ-009 wr_data  input  DATA_WIDTH  write word.
REQ-010 rd_valid  output  1  rd_data holds the oldest FIFO word.
REQ-011 rd_ready  input  1  consumer takes rd_data this cycle.
REQ-012 rd_data  output  DATA_WIDTH  read word, driven straight from ram_dout.
REQ-013 count  output  CNT_WIDTH  total words held (RAM plus presented word).
REQ-014 full  output  1  RAM holds DEPTH words.
REQ-015 empty  output  1  count == 0.
REQ-016 ram_en, ram_we  output  1 each  RAM port enable and write enable.
REQ-017 ram_addr  output  ADDR_WIDTH  RAM address; ram_di  output  DATA_WIDTH  RAM write data.
REQ-018 ram_dout  input  DATA_WIDTH  RAM read data, registered in the RAM, valid one cycle after a read, held unchanged until the next read.

Function
REQ-019 State: wptr, rptr (0..DEPTH-1), mem_cnt (0..DEPTH), rd_valid, last_grant (WR/RD).
REQ-020 read_elig = (mem_cnt > 0) && (!rd_valid || rd_ready).
REQ-021 wr_ready = (mem_cnt < DEPTH) && !(read_elig && last_grant == WR); wr_ready never depends on wr_valid.
REQ-022 write_go = wr_valid && wr_ready; read_go = read_elig && !write_go; at most one RAM access per cycle.
REQ-023 Contention: with both eligible, grants alternate (W,R,W,R...); last_grant takes the type of every issued access.
REQ-024 write_go: ram_en=1, ram_we=1, ram_addr=wptr, ram_di=wr_data; wptr advances, mem_cnt +1.
REQ-025 read_go: ram_en=1, ram_we=0, ram_addr=rptr; rptr advances, mem_cnt -1; rd_valid=1 next cycle.
REQ-026 No access: ram_en=0, ram_we=0, ram_addr=rptr; ram_di=wr_data always.
REQ-027 rd_valid clears on rd_valid && rd_ready without read_go; stays 1 on pop with read_go (back-to-back, one word/cycle).
REQ-028 Pointer wrap: DEPTH-1 -> 0 for both pointers.
REQ-029 Word written in cycle t is readable by a read issued in t+1 or later; no write-to-read bypass.
REQ-030 count = mem_cnt + rd_valid (max DEPTH+1); full = (mem_cnt == DEPTH); empty = (count == 0).
REQ-031 Write when full, or pop when rd_valid=0, is ignored with no state change.
REQ-032 Data order strictly FIFO; no word lost or duplicated.

Reset
REQ-033 rst=1 immediately forces wptr=0, rptr=0, mem_cnt=0, rd_valid=0, last_grant=RD, ram_en=0, ram_we=0; hence count=0, empty=1, full=0, wr_ready=1.
REQ-034 Reset mid-operation discards in-flight reads and stored words; RAM contents not cleared; rd_data undefined while rd_valid=0.

Verification
REQ-035 DEPTH=4, rd_ready=0, 0x11 written: cycle after, read issued (wr_ready=0 that cycle); next cycle rd_valid=1, rd_data=0x11, count=1.
REQ-036 DEPTH=4, rd_ready=0, wr_valid held with data 1..6: exactly 5 words accepted, count=5, full=1, wr_ready=0, rd_data=1.
REQ-037 DEPTH=4, wr_valid=1 and rd_ready=1 continuous after first word: ram_we alternates 1,0,1,0; rd_data sequence 1,2,3... with no gaps beyond arbitration.
REQ-038 DEPTH=4, stream 0..9 through with random wr_valid/rd_ready: output exactly 0..9 in order across pointer wrap.
REQ-039 rst asserted mid-stream between edges: rd_valid=0, count=0, empty=1, wr_ready=1 before the next clock edge.
REQ-040 Empty FIFO, rd_ready=1, wr_valid=0 for 10 cycles: ram_en=0, rd_valid=0 throughout.

Source files
------------

// File: rtl/fifo_sp_ctrl.sv
// fifo_sp_ctrl: FIFO controller in front of an external single-port RAM.
// One RAM access per cycle (write or read). Writes and reads alternate under
// contention. The RAM registers its read data, so a read issued in cycle t
// presents its word on rd_data (straight from ram_dout) in cycle t+1.
//
// Handshakes: a word moves on a port in any cycle where valid && ready is high
// at the rising clock edge. wr_ready never looks at wr_valid. rd_valid never
// looks at rd_ready. Once rd_valid is raised, rd_data holds until the word is taken.
module fifo_sp_ctrl #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  // Type of the most recent RAM access, used to alternate under contention.
  localparam logic [0:0] GRANT_RD = 1'b0;
  localparam logic [0:0] GRANT_WR = 1'b1;

  localparam logic [CNT_WIDTH-1:0]  DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [CNT_WIDTH-1:0]  mem_cnt;
  logic [0:0]            last_grant;
  logic                  read_elig;
  logic                  write_go;
  logic                  read_go;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] p);
    ptr_next = (p == LAST_A) ? '0 : p + 1'b1;
  endfunction

  // Arbitration: a read is eligible when RAM holds data and the output slot
  // is free or being emptied. A write yields when a read is eligible and the
  // previous grant was a write. rst gates both so the RAM port stays idle
  // while the state is held in reset.
  always_comb begin
    read_elig = (mem_cnt != '0) && (!rd_valid || rd_ready);
    wr_ready  = (mem_cnt < DEPTH_C) && !(read_elig && (last_grant == GRANT_WR));
    write_go  = wr_valid && wr_ready && !rst;
    read_go   = read_elig && !write_go && !rst;
  end

  // RAM port drive. When the port is idle, the address parks on the read pointer.
  always_comb begin
    ram_en   = write_go || read_go;
    ram_we   = write_go;
    ram_addr = write_go ? wptr : rptr;
    ram_di   = wr_data;
  end

  // Status outputs. count includes the word presented on rd_data.
  always_comb begin
    rd_data = ram_dout;
    count   = mem_cnt + {{(CNT_WIDTH-1){1'b0}}, rd_valid};
    full    = (mem_cnt == DEPTH_C);
    empty   = (count == '0);
  end

  // Pointer, occupancy, grant history and output-valid state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      mem_cnt    <= '0;
      rd_valid   <= 1'b0;
      last_grant <= GRANT_RD;
    end else begin
      if (write_go) begin
        wptr       <= ptr_next(wptr);
        mem_cnt    <= mem_cnt + 1'b1;
        last_grant <= GRANT_WR;
      end else if (read_go) begin
        rptr       <= ptr_next(rptr);
        mem_cnt    <= mem_cnt - 1'b1;
        last_grant <= GRANT_RD;
      end
      if (read_go) begin
        rd_valid <= 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sp_ctrl.sv
// tb_fifo_sp_ctrl: directed bench for fifo_sp_ctrl with DEPTH=4 and a behavioural
// registered-read RAM. A monitor records each accepted write in exp_q and
// checks each popped word against it. The stimulus thread drives inputs one
// time unit after each rising edge and checks directed values at the falling edge.
module tb_fifo_sp_ctrl;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];

  int checks;
  int failures;
  int acc_cnt;
  int pop_cnt;

  // Clock
  always #5 clk = ~clk;

  fifo_sp_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .full(full), .empty(empty),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_di(ram_di), .ram_dout(ram_dout)
  );

  // Single-port RAM with registered read data
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      else        ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: push accepted writes, pop and compare delivered words
  task automatic monitor_loop();
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        acc_cnt = 0;
        pop_cnt = 0;
      end else begin
        if (wr_valid && wr_ready) begin
          exp_q.push_back(wr_data);
          acc_cnt++;
        end
        if (rd_valid && rd_ready) begin
          pop_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_underflow actual=%0h required=none at %0t", rd_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("rd_data_order", 32'(rd_data), 32'(e));
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Drain with rd_ready high until empty, bounded
  task automatic drain(input string name);
    int n;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    n = 0;
    while (!empty && n < 40) begin
      step();
      n++;
    end
    @(negedge clk);
    chk({name, "_drained"}, 32'(empty), 32'd1);
    chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    rd_ready = 1'b0;
  endtask

  initial begin
    int val;
    int guard;
    checks = 0;
    failures = 0;
    acc_cnt = 0;
    pop_cnt = 0;
    rst = 1'b1;
    wr_valid = 1'b1;
    rd_ready = 1'b0;
    wr_data = 8'h5a;
    fork
      monitor_loop();
    join_none

    // Reset state, with wr_valid high while reset holds
    @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    step();
    wr_valid = 1'b0;
    rst = 1'b0;

    // Single write, then the read issued the following cycle
    wr_valid = 1'b1;
    wr_data = 8'h11;
    @(negedge clk);
    chk("w1_wr_ready", 32'(wr_ready), 32'd1);
    chk("w1_ram_we", 32'(ram_we), 32'd1);
    chk("w1_ram_addr", 32'(ram_addr), 32'd0);
    chk("w1_ram_di", 32'(ram_di), 32'h11);
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("r1_ram_en", 32'(ram_en), 32'd1);
    chk("r1_ram_we", 32'(ram_we), 32'd0);
    chk("r1_ram_addr", 32'(ram_addr), 32'd0);
    chk("r1_wr_ready", 32'(wr_ready), 32'd0);
    step();
    @(negedge clk);
    chk("r1_rd_valid", 32'(rd_valid), 32'd1);
    chk("r1_rd_data", 32'(rd_data), 32'h11);
    chk("r1_count", 32'(count), 32'd1);
    chk("r1_empty", 32'(empty), 32'd0);
    step();
    drain("single");

    // Fill with rd_ready low: 1..6 offered, 5 fit (4 in RAM plus presented)
    do_reset();
    val = 1;
    for (int i = 0; i < 12; i++) begin
      wr_valid = 1'b1;
      wr_data = DW'(val);
      @(negedge clk);
      if (wr_ready && val < 6) val++;
      step();
    end
    @(negedge clk);
    chk("fill_accepted", 32'(acc_cnt), 32'd5);
    chk("fill_count", 32'(count), 32'd5);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_wr_ready", 32'(wr_ready), 32'd0);
    chk("fill_rd_data", 32'(rd_data), 32'd1);
    step();
    drain("fill");
    chk("fill_pops", 32'(pop_cnt), 32'd5);

    // Continuous write and read: RAM accesses alternate write/read
    do_reset();
    val = 1;
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = DW'(val);
      @(negedge clk);
      chk("alt_ram_en", 32'(ram_en), 32'd1);
      chk("alt_ram_we", 32'(ram_we), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (wr_ready) val++;
      step();
    end
    drain("alt");
    chk("alt_pops", 32'(pop_cnt), 32'd4);

    // Stream 0..9 with random handshakes across pointer wrap
    do_reset();
    val = 0;
    guard = 0;
    while (pop_cnt < 10 && guard < 400) begin
      wr_valid = (val < 10) && ($urandom_range(0, 1) == 1);
      wr_data = DW'(val);
      rd_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (wr_valid && wr_ready) val++;
      step();
      guard++;
    end
    chk("stream_pops", 32'(pop_cnt), 32'd10);
    chk("stream_queue_left", 32'(exp_q.size()), 32'd0);
    wr_valid = 1'b0;
    rd_ready = 1'b0;

    // Reset asserted between edges mid-stream
    do_reset();
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = DW'(8'ha0 + i);
      step();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 32'd3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    wr_valid = 1'b1;
    #1;
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("mid_rst_ram_en", 32'(ram_en), 32'd0);
    step();
    rst = 1'b0;
    wr_valid = 1'b0;

    // Empty FIFO with rd_ready high: no RAM access, no output
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ram_en", 32'(ram_en), 32'd0);
      chk("idle_rd_valid", 32'(rd_valid), 32'd0);
      step();
    end
    rd_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
